lsu32: RTL

- Load/store unit sitting directly downstream of the ALU32 stage.
- Takes the ALU result as the effective address and performs RV32I byte, half and word loads/stores over a simple req/ack data-memory bus.
- Stalls the single-cycle core until the access completes.
- Returns a sign- or zero-extended load result to the writeback mux.

---
 rtl/lsu32.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu32.sv
// RV32I load/store unit: req/ack data-memory bus master with byte-lane steering and load extension.
// Optional bus timeout is compiled in when LSU_TIMEOUT_EN is defined.
module lsu32 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Stall,
    output logic        AccessErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWData,
    input  logic [31:0] BusRData,
    input  logic        BusAck
);

    // state | meaning
    // IDLE  | waiting for MemRead/MemWrite; illegal accesses flagged here
    // BUS   | request on the bus, waiting for BusAck
    // DONE  | one unstalled cycle so the core retires the instruction
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state, state_nx;
    logic        op, legal, aligned, start, req_err, ack_take;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx, rdata_fmt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        tmo_hit, tmo_err;

    always_comb begin
        op = MemRead | MemWrite;
        case (Funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~MemWrite;
            default:                legal = 1'b0;
        endcase
        case (Funct3[1:0])
            2'b01:   aligned = ~Addr[0];
            2'b10:   aligned = (Addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (Funct3[1:0])
            2'b00: begin
                be_nx    = 4'b0001 << Addr[1:0];
                wdata_nx = {4{WData[7:0]}};
            end
            2'b01: begin
                be_nx    = 4'b0011 << Addr[1:0];
                wdata_nx = {2{WData[15:0]}};
            end
            default: begin
                be_nx    = 4'b1111;
                wdata_nx = WData;
            end
        endcase
    end

    always_comb begin
        byte_sel = BusRData[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? BusRData[31:16] : BusRData[15:0];
        case (f3_q)
            3'b000:  rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  rdata_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  rdata_fmt = {24'd0, byte_sel};
            3'b101:  rdata_fmt = {16'd0, half_sel};
            default: rdata_fmt = BusRData;
        endcase
    end

    always_comb begin
        state_nx  = state;
        Stall     = 1'b0;
        AccessErr = 1'b0;
        start     = 1'b0;
        req_err   = 1'b0;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (op) begin
                    if (legal && aligned) begin
                        start    = 1'b1;
                        Stall    = 1'b1;
                        state_nx = BUS;
                    end else begin
                        req_err   = 1'b1;
                        AccessErr = 1'b1;
                    end
                end
            end
            BUS: begin
                Stall = 1'b1;
                if (BusAck) begin
                    ack_take = 1'b1;
                    state_nx = DONE;
                end else if (tmo_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                AccessErr = tmo_err;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Outputs stay quiet during reset even if an access is being requested.
        if (rst) begin
            Stall     = 1'b0;
            AccessErr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            RData    <= '0;
            BusReq   <= 1'b0;
            BusWe    <= 1'b0;
            BusAddr  <= '0;
            BusBe    <= '0;
            BusWData <= '0;
            f3_q     <= '0;
            off_q    <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                BusReq   <= 1'b1;
                BusWe    <= MemWrite;
                BusAddr  <= {Addr[31:2], 2'b00};
                BusBe    <= be_nx;
                BusWData <= wdata_nx;
                f3_q     <= Funct3;
                off_q    <= Addr[1:0];
            end
            if (req_err) begin
                RData <= '0;
            end
            if (ack_take) begin
                BusReq <= 1'b0;
                if (!BusWe) begin
                    RData <= rdata_fmt;
                end
            end
            if (tmo_hit) begin
                BusReq <= 1'b0;
                RData  <= '0;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == BUS) && !BusAck && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (start) begin
                tmo_cnt <= '0;
                tmo_err <= 1'b0;
            end else if (state == BUS && !BusAck) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
    assign tmo_hit    = 1'b0;
    assign tmo_err    = 1'b0;
`endif

endmodule
